// File: rtl/stage_two_pkg.sv
// Shared types for the execute stage: ALU control encodings, iterative-unit states
// and the iteration count.
package stage_two_pkg;

  typedef enum logic [3:0] {
    CTRL_ADD = 4'd0,
    CTRL_SUB = 4'd1,
    CTRL_AND = 4'd2,
    CTRL_OR  = 4'd3,
    CTRL_MUL = 4'd4,
    CTRL_DIV = 4'd5,
    CTRL_SLL = 4'd8,
    CTRL_SRL = 4'd9,
    CTRL_ROL = 4'd10,
    CTRL_ROR = 4'd11
  } control_e;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_RUN,
    DIV_DONE
  } div_state_e;

  localparam int DIV_CYCLES = 16;
  localparam int CNT_W      = $clog2(DIV_CYCLES);

endpackage

// File: rtl/stage_two_alu_iter_unit.sv
// Iterative unit: restoring divider, plus a shift-add multiplier when
// STAGE_TWO_ITER_MUL_EN is defined. One result bit per RUN cycle.
module alu_iter_unit
  import stage_two_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        halt,
  input  logic        start,
  input  control_e    op,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  div_state_e       state;
  logic [CNT_W-1:0] count;
  logic [15:0]      hi_q, lo_q, b_q;
  logic [16:0]      step_shift, step_diff;
  logic [15:0]      hi_next, lo_next;
  logic             go;
`ifdef STAGE_TWO_ITER_MUL_EN
  logic             mul_q;
  logic [16:0]      step_sum;
`endif

  // A zero divisor is handled combinationally upstream and never enters RUN.
  assign go     = start && ((op == CTRL_MUL) || (b != 16'd0));
  assign busy   = ((state == DIV_IDLE) && go) || (state == DIV_RUN);
  assign done   = (state == DIV_DONE);
  assign result = {hi_q, lo_q};

  always_comb begin
    step_shift = {hi_q, lo_q[15]};
    step_diff  = step_shift - {1'b0, b_q};
    if (!step_diff[16]) begin
      hi_next = step_diff[15:0];
      lo_next = {lo_q[14:0], 1'b1};
    end else begin
      hi_next = step_shift[15:0];
      lo_next = {lo_q[14:0], 1'b0};
    end
`ifdef STAGE_TWO_ITER_MUL_EN
    step_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : 17'd0);
    if (mul_q) begin
      hi_next = step_sum[16:1];
      lo_next = {step_sum[0], lo_q[15:1]};
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= DIV_IDLE;
      count <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      b_q   <= '0;
`ifdef STAGE_TWO_ITER_MUL_EN
      mul_q <= 1'b0;
`endif
    end else if (!halt) begin
      case (state)
        DIV_IDLE: if (go) begin
          state <= DIV_RUN;
          count <= CNT_W'(DIV_CYCLES - 1);
          hi_q  <= '0;
          lo_q  <= a;
          b_q   <= b;
`ifdef STAGE_TWO_ITER_MUL_EN
          mul_q <= (op == CTRL_MUL);
`endif
        end
        DIV_RUN: begin
          hi_q  <= hi_next;
          lo_q  <= lo_next;
          count <= count - CNT_W'(1);
          if (count == '0) state <= DIV_DONE;
        end
        DIV_DONE: state <= DIV_IDLE;
        default:  state <= DIV_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/stage_two.sv
// Execute stage: forwarding muxes, ALU, iterative divider and the stage-three register.
// Define STAGE_TWO_ITER_MUL_EN to run MUL through the iterative unit.
module stage_two
  import stage_two_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        halt_sys,
  input  logic [1:0]  in_memc,
  input  logic        in_reg_wr,
  input  logic [15:0] in_alu_a,
  input  logic [15:0] in_alu_b,
  input  logic [15:0] in_R1_data,
  input  logic        in_haz1,
  input  logic        in_haz2,
  input  logic        in_R0_en,
  input  control_e    in_alu_ctrl,
  input  logic [15:0] in_instr,
  input  logic [15:0] s3_data,
  output logic [31:0] aluout,
  output logic        busy,
  output logic        div0,
  output logic        overflow,
  output logic [1:0]  out_memc,
  output logic        out_reg_wr,
  output logic [31:0] out_alu,
  output logic [15:0] out_R1_data,
  output logic        out_R0_en,
  output logic [15:0] out_instr
);

  logic [15:0] op_a, op_b, add_res, sub_res;
  logic [3:0]  sh;
  logic        iter_start, iter_busy, iter_done;
  logic [31:0] iter_result;

  assign op_a    = in_haz1 ? s3_data : in_alu_a;
  assign op_b    = in_haz2 ? s3_data : in_alu_b;
  assign add_res = op_a + op_b;
  assign sub_res = op_a - op_b;
  assign sh      = op_b[3:0];

`ifdef STAGE_TWO_ITER_MUL_EN
  assign iter_start = (in_alu_ctrl == CTRL_DIV) || (in_alu_ctrl == CTRL_MUL);
`else
  logic [31:0] mul_full;
  assign mul_full   = 32'(op_a) * 32'(op_b);
  assign iter_start = (in_alu_ctrl == CTRL_DIV);
`endif

  alu_iter_unit u_iter (
    .clk    (clk),
    .rst    (rst),
    .halt   (halt_sys),
    .start  (iter_start),
    .op     (in_alu_ctrl),
    .a      (op_a),
    .b      (op_b),
    .busy   (iter_busy),
    .done   (iter_done),
    .result (iter_result)
  );

  assign busy = iter_busy;

  always_comb begin
    aluout   = '0;
    overflow = 1'b0;
    div0     = 1'b0;
    case (in_alu_ctrl)
      CTRL_ADD: begin
        aluout   = {16'h0, add_res};
        overflow = (op_a[15] == op_b[15]) && (add_res[15] != op_a[15]);
      end
      CTRL_SUB: begin
        aluout   = {16'h0, sub_res};
        overflow = (op_a[15] != op_b[15]) && (sub_res[15] != op_a[15]);
      end
      CTRL_AND: aluout = {16'h0, op_a & op_b};
      CTRL_OR:  aluout = {16'h0, op_a | op_b};
`ifdef STAGE_TWO_ITER_MUL_EN
      CTRL_MUL: aluout = iter_done ? iter_result : '0;
`else
      CTRL_MUL: aluout = mul_full;
`endif
      CTRL_DIV: begin
        if (op_b == 16'd0) begin
          aluout = {op_a, 16'hFFFF};
          div0   = 1'b1;
        end else begin
          aluout = iter_done ? iter_result : '0;
        end
      end
      CTRL_SLL: aluout = {16'h0, op_a << sh};
      CTRL_SRL: aluout = {16'h0, op_a >> sh};
      CTRL_ROL: aluout = {16'h0, (op_a << sh) | (op_a >> (5'd16 - {1'b0, sh}))};
      CTRL_ROR: aluout = {16'h0, (op_a >> sh) | (op_a << (5'd16 - {1'b0, sh}))};
      default:  aluout = '0;
    endcase
  end

  // While the iterative unit is busy, stage three sees bubbles; payload fields hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_memc    <= '0;
      out_reg_wr  <= 1'b0;
      out_alu     <= '0;
      out_R1_data <= '0;
      out_R0_en   <= 1'b0;
      out_instr   <= '0;
    end else if (!halt_sys) begin
      if (busy) begin
        out_memc   <= '0;
        out_reg_wr <= 1'b0;
        out_R0_en  <= 1'b0;
      end else begin
        out_memc    <= in_memc;
        out_reg_wr  <= in_reg_wr && !div0;
        out_alu     <= aluout;
        out_R1_data <= in_R1_data;
        out_R0_en   <= in_R0_en;
        out_instr   <= in_instr;
      end
    end
  end

endmodule

// File: tb/tb_stage_two.sv
// Self-checking bench for stage_two: directed cases plus randomized ops against an
// arithmetic reference model.
module tb_stage_two;
  import stage_two_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        halt_sys;
  logic [1:0]  in_memc;
  logic        in_reg_wr;
  logic [15:0] in_alu_a, in_alu_b, in_R1_data;
  logic        in_haz1, in_haz2, in_R0_en;
  control_e    in_alu_ctrl;
  logic [15:0] in_instr, s3_data;
  logic [31:0] aluout;
  logic        busy, div0, overflow;
  logic [1:0]  out_memc;
  logic        out_reg_wr;
  logic [31:0] out_alu;
  logic [15:0] out_R1_data;
  logic        out_R0_en;
  logic [15:0] out_instr;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  stage_two dut (
    .clk(clk), .rst(rst), .halt_sys(halt_sys),
    .in_memc(in_memc), .in_reg_wr(in_reg_wr),
    .in_alu_a(in_alu_a), .in_alu_b(in_alu_b), .in_R1_data(in_R1_data),
    .in_haz1(in_haz1), .in_haz2(in_haz2), .in_R0_en(in_R0_en),
    .in_alu_ctrl(in_alu_ctrl), .in_instr(in_instr), .s3_data(s3_data),
    .aluout(aluout), .busy(busy), .div0(div0), .overflow(overflow),
    .out_memc(out_memc), .out_reg_wr(out_reg_wr), .out_alu(out_alu),
    .out_R1_data(out_R1_data), .out_R0_en(out_R0_en), .out_instr(out_instr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  // Reference ALU from plain integer arithmetic: returns {overflow, result}.
  function automatic logic [32:0] ref_alu(input int op, input logic [15:0] a, input logic [15:0] b);
    int     ia, ib, sa, sb, s, sh;
    longint p;
    logic [31:0] r;
    logic        ovf;
    ia = a; ib = b; sa = $signed(a); sb = $signed(b); sh = ib % 16;
    r = '0; ovf = 1'b0;
    case (op)
      0: begin r = (ia + ib) & 'hFFFF; s = sa + sb; ovf = (s > 32767) || (s < -32768); end
      1: begin r = (ia - ib) & 'hFFFF; s = sa - sb; ovf = (s > 32767) || (s < -32768); end
      2: r = ia & ib;
      3: r = ia | ib;
      4: begin p = longint'(ia) * longint'(ib); r = p[31:0]; end
      5: r = (ib == 0) ? ((ia << 16) | 'hFFFF) : (((ia % ib) << 16) | (ia / ib));
      8: r = (ia << sh) & 'hFFFF;
      9: r = ia >> sh;
      10: r = ((ia << sh) | (ia >> (16 - sh))) & 'hFFFF;
      11: r = ((ia >> sh) | (ia << (16 - sh))) & 'hFFFF;
      default: r = '0;
    endcase
    return {ovf, r};
  endfunction

  task automatic set_nop();
    in_alu_ctrl = CTRL_ADD; in_alu_a = '0; in_alu_b = '0; in_R1_data = '0;
    in_haz1 = 1'b0; in_haz2 = 1'b0; s3_data = '0; in_reg_wr = 1'b0;
    in_memc = '0; in_R0_en = 1'b0; in_instr = '0;
  endtask

  task automatic drive(input control_e op, input logic [15:0] a, input logic [15:0] b,
                       input logic h1, input logic h2, input logic [15:0] s3,
                       input logic wr, input logic [1:0] memc, input logic r0,
                       input logic [15:0] r1, input logic [15:0] instr);
    in_alu_ctrl = op; in_alu_a = a; in_alu_b = b; in_haz1 = h1; in_haz2 = h2;
    s3_data = s3; in_reg_wr = wr; in_memc = memc; in_R0_en = r0;
    in_R1_data = r1; in_instr = instr;
  endtask

  // Single-cycle op: check combinational outputs, cross one edge, check stage-three register.
  task automatic step_check(input string tag);
    logic [15:0] ea, eb;
    logic [32:0] m;
    logic        exp_wr;
    ea = in_haz1 ? s3_data : in_alu_a;
    eb = in_haz2 ? s3_data : in_alu_b;
    m  = ref_alu(int'(in_alu_ctrl), ea, eb);
    exp_wr = in_reg_wr && !((in_alu_ctrl == CTRL_DIV) && (eb == 16'd0));
    #1;
    check({tag, ".aluout"}, aluout, m[31:0]);
    check({tag, ".ovf"}, {31'd0, overflow}, {31'd0, m[32]});
    check({tag, ".div0"}, {31'd0, div0}, {31'd0, (in_alu_ctrl == CTRL_DIV) && (eb == 16'd0)});
    check({tag, ".busy"}, {31'd0, busy}, 32'd0);
    @(negedge clk);
    check({tag, ".out_alu"}, out_alu, m[31:0]);
    check({tag, ".out_wr"}, {31'd0, out_reg_wr}, {31'd0, exp_wr});
    check({tag, ".out_misc"}, {out_memc, out_R0_en, out_R1_data, out_instr},
          {in_memc, in_R0_en, in_R1_data, in_instr});
  endtask

  // Iterative op: measure busy length, verify bubbles, then the registered result.
  task automatic run_iter(input string tag, input control_e op, input logic [15:0] a,
                          input logic [15:0] b, input int halt_at, input int halt_len,
                          input int exp_busy, input logic [31:0] exp);
    int busy_cycles, bubble_bad;
    logic [15:0] instr;
    busy_cycles = 0; bubble_bad = 0; instr = a ^ 16'h5A5A;
    drive(op, a, b, 1'b0, 1'b0, 16'h0, 1'b1, 2'b10, 1'b1, 16'hBEEF, instr);
    for (int cyc = 0; cyc < 200; cyc++) begin
      halt_sys = (cyc >= halt_at) && (cyc < halt_at + halt_len);
      #1;
      if (!busy) break;
      busy_cycles++;
      if (cyc > 0 && (out_reg_wr !== 1'b0 || out_memc !== 2'b00 || out_R0_en !== 1'b0))
        bubble_bad++;
      @(negedge clk);
    end
    halt_sys = 1'b0;
    check({tag, ".busy_len"}, busy_cycles, exp_busy);
    check({tag, ".bubbles"}, bubble_bad, 0);
    check({tag, ".aluout"}, aluout, exp);
    @(negedge clk);
    check({tag, ".out_alu"}, out_alu, exp);
    check({tag, ".out_ctl"}, {out_reg_wr, out_memc, out_R0_en, out_instr},
          {1'b1, 2'b10, 1'b1, instr});
    set_nop();
  endtask

  initial begin
    int          ops[$];
    logic [15:0] ra, rb;
    control_e    rop;
    logic        h2;

    set_nop();
    halt_sys = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst.out_alu", out_alu, 32'd0);
    check("rst.out_fields", {out_memc, out_reg_wr, out_R0_en, out_R1_data, out_instr}, 36'd0);
    check("rst.flags", {busy, div0, overflow}, 3'b000);
    @(negedge clk);
    rst = 1'b0;

    // Signed overflow on ADD.
    drive(CTRL_ADD, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h0, 1'b1, 2'b01, 1'b0, 16'h1234, 16'h0A01);
    #1;
    check("add.const", aluout, 32'h0000_8000);
    check("add.ovf_const", {31'd0, overflow}, 32'd1);
    step_check("add");

`ifndef STAGE_TWO_ITER_MUL_EN
    drive(CTRL_MUL, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 16'h0, 1'b1, 2'b00, 1'b1, 16'h0, 16'h0A02);
    #1;
    check("mul.const", aluout, 32'hFFFE_0001);
    step_check("mul");
`else
    run_iter("mul_iter", CTRL_MUL, 16'hFFFF, 16'hFFFF, -1, 0, 17, 32'hFFFE_0001);
    run_iter("mul_iter0", CTRL_MUL, 16'h1234, 16'h0000, -1, 0, 17, 32'h0000_0000);
`endif

    run_iter("div100_7", CTRL_DIV, 16'd100, 16'd7, -1, 0, 17, {16'd2, 16'd14});
    // Back-to-back: the next call drives another DIV right after DONE.
    run_iter("div_b2b", CTRL_DIV, 16'hFFFF, 16'd1, -1, 0, 17, {16'd0, 16'hFFFF});
    run_iter("div_small", CTRL_DIV, 16'd3, 16'hFFFF, -1, 0, 17, {16'd3, 16'd0});
    run_iter("div_halt", CTRL_DIV, 16'hFFFF, 16'h0010, 6, 3, 20, {16'h000F, 16'h0FFF});

    // Divide by zero.
    drive(CTRL_DIV, 16'd5, 16'd0, 1'b0, 1'b0, 16'h0, 1'b1, 2'b11, 1'b0, 16'h0, 16'h0A03);
    #1;
    check("div0.const", aluout, 32'h0005_FFFF);
    check("div0.pulse", {31'd0, div0}, 32'd1);
    step_check("div0");
    set_nop();
    #1;
    check("div0.after", {busy, div0}, 2'b00);
    @(negedge clk);

    // Forwarding on both operands.
    drive(CTRL_OR, 16'h9999, 16'h0001, 1'b1, 1'b0, 16'h0010, 1'b1, 2'b00, 1'b0, 16'h0, 16'h0A04);
    #1;
    check("fwd_a.const", aluout, 32'h0000_0011);
    step_check("fwd_a");
    drive(CTRL_SUB, 16'h0005, 16'hAAAA, 1'b0, 1'b1, 16'h0007, 1'b1, 2'b00, 1'b0, 16'h0, 16'h0A05);
    step_check("fwd_b");

    // Reset during RUN aborts the divide.
    drive(CTRL_DIV, 16'd1000, 16'd3, 1'b0, 1'b0, 16'h0, 1'b1, 2'b10, 1'b1, 16'hCAFE, 16'h0A06);
    repeat (5) @(negedge clk);
    #2;
    check("rstrun.busy_pre", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    set_nop();
    #1;
    check("rstrun.busy", {31'd0, busy}, 32'd0);
    check("rstrun.out", {out_alu, out_memc, out_reg_wr, out_R0_en, out_R1_data, out_instr}, 68'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("rstrun.after", {busy, out_reg_wr, out_alu}, 34'd0);
    @(negedge clk);

    // Randomized single-cycle ops.
    ops = '{0, 1, 2, 3, 5, 8, 9, 10, 11};
`ifndef STAGE_TWO_ITER_MUL_EN
    ops.push_back(4);
`endif
    for (int i = 0; i < 40; i++) begin
      rop = control_e'(ops[$urandom_range(0, ops.size() - 1)]);
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      h2  = 1'($urandom);
      if (rop == CTRL_DIV) begin rb = 16'd0; h2 = 1'b0; end
      drive(rop, ra, rb, 1'($urandom), h2, 16'($urandom), 1'($urandom), 2'($urandom),
            1'($urandom), 16'($urandom), 16'($urandom));
      step_check($sformatf("rnd%0d", i));
    end

    // Randomized divides.
    for (int i = 0; i < 4; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom_range(1, 65535));
      run_iter($sformatf("rdiv%0d", i), CTRL_DIV, ra, rb, -1, 0, 17, {ra % rb, ra / rb});
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
